dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage
//  (EXMEM address/data/MemRead/MemWrite) and the 256-bit off-chip data memory.

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_sram.sv | 70 +++++++
 rtl/dcache_controller.sv | 163 ++++++++++++++++
 tb/tb_dcache_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, state encoding and address helpers shared by the
// L1 data cache controller and its storage arrays.
package dcache_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int LINE_W    = 256;
  localparam int NUM_LINES = 16;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int OFF_W     = 5;
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W    = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL_DONE
  } state_e;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WSEL_W-1:0] wsel_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;

  function automatic logic [ADDR_W-1:0] line_addr(
    input tag_t t,
    input idx_t i
  );
    return {t, i, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty and line data arrays, async read port,
// sync per-word store write and full-line refill write.
// Ports: rd_* lookup, word_* store port, line_* refill port.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  idx_t  rd_idx_i,
  output tag_t  rd_tag_o,
  output logic  rd_valid_o,
  output logic  rd_dirty_o,
  output line_t rd_line_o,
  input  logic  word_we_i,
  input  idx_t  word_idx_i,
  input  wsel_t word_sel_i,
  input  word_t word_i,
  input  logic  line_we_i,
  input  idx_t  line_idx_i,
  input  tag_t  line_tag_i,
  input  line_t line_i
);

  tag_t  tag_q  [NUM_LINES];
  line_t data_q [NUM_LINES];

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [NUM_LINES-1:0] dirty_q;
  logic [NUM_LINES-1:0] dirty_d;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (word_we_i) begin
      dirty_d[word_idx_i] = 1'b1;
    end
    if (line_we_i) begin
      valid_d[line_idx_i] = 1'b1;
      dirty_d[line_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[line_idx_i]  <= line_tag_i;
      data_q[line_idx_i] <= line_i;
    end
    if (word_we_i) begin
      data_q[word_idx_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate L1 D-cache.
// Ports: cpu_* MEM-stage request/stall, mem_* 256-bit line memory port.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  tag_t  req_tag;
  idx_t  req_idx;
  wsel_t req_wsel;
  logic  unused_addr;

  assign req_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = cpu_addr_i[OFF_W +: IDX_W];
  assign req_wsel    = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr = ^cpu_addr_i[1:0];

  tag_t  rd_tag;
  logic  rd_valid;
  logic  rd_dirty;
  line_t rd_line;
  logic  word_we;
  logic  line_we;

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  line_t             wdata_q, wdata_d;
  tag_t              mtag_q, mtag_d;
  idx_t              midx_q, midx_d;

  logic  hit;
  logic  idle;
  logic  ack_ok;
  word_t rd_word;

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (req_idx),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_line_o  (rd_line),
    .word_we_i  (word_we),
    .word_idx_i (req_idx),
    .word_sel_i (req_wsel),
    .word_i     (cpu_data_i),
    .line_we_i  (line_we),
    .line_idx_i (midx_q),
    .line_tag_i (mtag_q),
    .line_i     (mem_data_i)
  );

  assign hit     = rd_valid & (rd_tag == req_tag);
  assign idle    = (state_q == IDLE);
  assign rd_word = rd_line[req_wsel*WORD_W +: WORD_W];

  // Acks only count while a request is actually on the bus.
  assign ack_ok  = mem_ack_i & en_q;
  assign word_we = cpu_req_i & cpu_write_i & hit & idle;
  assign line_we = (state_q == ALLOCATE) & ack_ok;

  assign cpu_stall_o = cpu_req_i & (~hit | ~idle);
  assign cpu_data_o  = (cpu_req_i & ~cpu_write_i & hit & idle)
                     ? rd_word : '0;

  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;

  // Miss tag/index are latched so the refill lands in the right line
  // even if the CPU drops its request mid-miss.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mtag_d  = mtag_q;
    midx_d  = midx_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i & ~hit) begin
          mtag_d = req_tag;
          midx_d = req_idx;
          en_d   = 1'b1;
          if (rd_valid & rd_dirty) begin
            state_d = WRITEBACK;
            wr_d    = 1'b1;
            addr_d  = line_addr(rd_tag, req_idx);
            wdata_d = rd_line;
          end else begin
            state_d = ALLOCATE;
            wr_d    = 1'b0;
            addr_d  = line_addr(req_tag, req_idx);
          end
        end
      end
      WRITEBACK: begin
        // Enable drops for one cycle between write-back and fetch.
        if (ack_ok) begin
          state_d = ALLOCATE;
          en_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = line_addr(mtag_q, midx_q);
          wdata_d = '0;
        end
      end
      ALLOCATE: begin
        if (ack_ok) begin
          state_d = REFILL_DONE;
          en_d    = 1'b0;
        end else if (!en_q) begin
          en_d = 1'b1;
        end
      end
      REFILL_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mtag_q  <= '0;
      midx_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mtag_q  <= mtag_d;
      midx_q  <= midx_d;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: scoreboard bench for dcache_controller with a
// behavioural line memory and a word-level reference of CPU-visible data.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_pass = 0;
  int n_total = 0;

  logic [255:0] mem_model [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  exp_q [$];

  logic         auto_ack = 1'b0;
  logic         man_ack = 1'b0;
  logic         auto_ack_q = 1'b0;
  int           lat = 3;
  int           cnt = 0;
  int           target = 1;
  logic [255:0] resp_line = '0;
  int           wb_cnt = 0;
  logic [31:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;

  assign mem_ack_i  = auto_ack ? auto_ack_q : man_ack;
  assign mem_data_i = resp_line;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = (la + 32'(i*4)) ^ 32'h5A00_0000;
    if (la == 32'h40) l[31:0] = 32'h1111_1111;
    return l;
  endfunction

  function automatic logic [255:0] model_read(input logic [31:0] la);
    if (mem_model.exists(la)) return mem_model[la];
    return init_line(la);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = model_read({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  // Memory responder: line data follows the address, acks after latency.
  always begin
    @(negedge clk);
    resp_line  = model_read(mem_addr_o);
    auto_ack_q = 1'b0;
    if (auto_ack && mem_enable_o) begin
      if (cnt == 0)
        target = (lat == 0) ? int'($urandom_range(1, 20)) : lat;
      cnt++;
      if (cnt >= target) auto_ack_q = 1'b1;
    end else begin
      cnt = 0;
    end
  end

  always begin
    @(posedge clk);
    if (mem_enable_o && mem_write_o && mem_ack_i) begin
      mem_model[mem_addr_o] = mem_data_o;
      wb_cnt++;
      wb_addr = mem_addr_o;
      wb_data = mem_data_o;
    end
  end

  task automatic access(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic [31:0] rdata);
    int n;
    logic [31:0] e;
    @(negedge clk);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = a;
    cpu_data_i  = d;
    if (!wr) exp_q.push_back(ref_read(a));
    n = 0;
    #1;
    while (cpu_stall_o && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    rdata = cpu_data_o;
    n_total++;
    if (n >= 300) $display("FAIL access_timeout addr=%h stalls=%0d required<300", a, n);
    else n_pass++;
    if (!wr) begin
      e = exp_q.pop_front();
      n_total++;
      if (cpu_data_o !== e)
        $display("FAIL load_data addr=%h got=%h want=%h", a, cpu_data_o, e);
      else n_pass++;
    end else begin
      ref_mem[{a[31:2], 2'b00}] = d;
    end
    stalls = n;
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({cpu_stall_o, mem_enable_o, mem_write_o} !== 3'b000)
      $display("FAIL reset_ctrl got=%b want=000", {cpu_stall_o, mem_enable_o, mem_write_o});
    else n_pass++;
    n_total++;
    if (mem_addr_o !== 32'h0) $display("FAIL reset_addr got=%h want=0", mem_addr_o);
    else n_pass++;
    n_total++;
    if (mem_data_o !== 256'h0) $display("FAIL reset_mdata got=%h want=0", mem_data_o);
    else n_pass++;
    n_total++;
    if (cpu_data_o !== 32'h0) $display("FAIL reset_cdata got=%h want=0", cpu_data_o);
    else n_pass++;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_alloc_first;
    logic [31:0] e;
    auto_ack = 1'b0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40;
    exp_q.push_back(ref_read(32'h40));
    #1;
    n_total++;
    if ({cpu_stall_o, mem_enable_o} !== 2'b10)
      $display("FAIL t1_detect stall/en got=%b want=10", {cpu_stall_o, mem_enable_o});
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h40})
      $display("FAIL t1_alloc en/wr/addr got=%b%b/%h want=10/00000040",
               mem_enable_o, mem_write_o, mem_addr_o);
    else n_pass++;
    @(negedge clk);
    man_ack = 1'b1;
    #1;
    n_total++;
    if (cpu_stall_o !== 1'b1) $display("FAIL t1_ack_stall got=%b want=1", cpu_stall_o);
    else n_pass++;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    n_total++;
    if ({cpu_stall_o, mem_enable_o} !== 2'b10)
      $display("FAIL t1_refill_done stall/en got=%b want=10", {cpu_stall_o, mem_enable_o});
    else n_pass++;
    @(negedge clk); #1;
    e = exp_q.pop_front();
    n_total++;
    if (cpu_stall_o !== 1'b0) $display("FAIL t1_hit_stall got=%b want=0", cpu_stall_o);
    else n_pass++;
    n_total++;
    if (cpu_data_o !== e || e !== 32'h1111_1111)
      $display("FAIL t1_data got=%h want=11111111", cpu_data_o);
    else n_pass++;
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic test_read_hit;
    int s;
    logic [31:0] r;
    auto_ack = 1'b1; lat = 3;
    access(1'b0, 32'h44, 32'h0, s, r);
    n_total++;
    if (s !== 0 || r !== 32'h5A00_0044)
      $display("FAIL t2_hit stalls=%0d data=%h want 0/5a000044", s, r);
    else n_pass++;
  endtask

  task automatic test_dirty_evict;
    int s;
    logic [31:0] r;
    logic [31:0] e;
    auto_ack = 1'b1;
    access(1'b1, 32'h40, 32'hDEAD_BEEF, s, r);
    n_total++;
    if (s !== 0) $display("FAIL t3_store_hit stalls=%0d want 0", s);
    else n_pass++;
    auto_ack = 1'b0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h240;
    exp_q.push_back(ref_read(32'h240));
    @(negedge clk); #1;
    n_total++;
    if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b11, 32'h40})
      $display("FAIL t3_wb en/wr/addr got=%b%b/%h want=11/00000040",
               mem_enable_o, mem_write_o, mem_addr_o);
    else n_pass++;
    n_total++;
    if (mem_data_o[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL t3_wb_data got=%h want=deadbeef", mem_data_o[31:0]);
    else n_pass++;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    n_total++;
    if (mem_enable_o !== 1'b0) $display("FAIL t3_gap en got=%b want=0", mem_enable_o);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h240})
      $display("FAIL t3_alloc en/wr/addr got=%b%b/%h want=10/00000240",
               mem_enable_o, mem_write_o, mem_addr_o);
    else n_pass++;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk); #1;
    e = exp_q.pop_front();
    n_total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== e)
      $display("FAIL t3_load stall=%b data=%h want 0/%h", cpu_stall_o, cpu_data_o, e);
    else n_pass++;
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic test_store_miss;
    int s;
    logic [31:0] r;
    auto_ack = 1'b1; lat = 3;
    access(1'b1, 32'h80, 32'hCAFE_F00D, s, r);
    n_total++;
    if (s !== 5) $display("FAIL t4_clean_miss stalls=%0d want 5", s);
    else n_pass++;
    access(1'b0, 32'h280, 32'h0, s, r);
    n_total++;
    if (s !== 9) $display("FAIL t4_dirty_miss stalls=%0d want 9", s);
    else n_pass++;
    n_total++;
    if (wb_addr !== 32'h80 || wb_data[31:0] !== 32'hCAFE_F00D)
      $display("FAIL t4_wb addr=%h w0=%h want 00000080/cafef00d", wb_addr, wb_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    int s;
    logic [31:0] r;
    auto_ack = 1'b0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h300;
    exp_q.push_back(ref_read(32'h300));
    n = 0;
    #1;
    while (!mem_enable_o && n < 10) begin
      @(negedge clk); #1; n++;
    end
    n_total++;
    if (n >= 10) $display("FAIL t5_no_enable waited=%0d want<10", n);
    else n_pass++;
    #1;
    rst_i = 1'b0;
    #1;
    n_total++;
    if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b00, 32'h0})
      $display("FAIL t5_async en/wr/addr got=%b%b/%h want=00/0", mem_enable_o, mem_write_o, mem_addr_o);
    else n_pass++;
    void'(exp_q.pop_back());
    @(negedge clk);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    auto_ack = 1'b1; lat = 2;
    access(1'b0, 32'h40, 32'h0, s, r);
    n_total++;
    if (s !== 4 || r !== 32'hDEAD_BEEF)
      $display("FAIL t5_reload stalls=%0d data=%h want 4/deadbeef", s, r);
    else n_pass++;
  endtask

  task automatic test_req_drop;
    int s;
    logic [31:0] r;
    auto_ack = 1'b1; lat = 3;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h500;
    repeat (2) @(negedge clk);
    cpu_req_i = 1'b0;
    cpu_addr_i = 32'h0;
    repeat (12) @(negedge clk);
    #1;
    n_total++;
    if (mem_enable_o !== 1'b0) $display("FAIL drop_idle en=%b want 0", mem_enable_o);
    else n_pass++;
    access(1'b0, 32'h500, 32'h0, s, r);
    n_total++;
    if (s !== 0) $display("FAIL drop_refilled stalls=%0d want 0", s);
    else n_pass++;
  endtask

  task automatic test_spurious_random;
    int s;
    logic [31:0] r;
    logic [31:0] a;
    auto_ack = 1'b0;
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    n_total++;
    if ({mem_enable_o, cpu_stall_o} !== 2'b00)
      $display("FAIL t6_spurious en/stall got=%b want=00", {mem_enable_o, cpu_stall_o});
    else n_pass++;
    auto_ack = 1'b1; lat = 0;
    access(1'b0, 32'h40, 32'h0, s, r);
    n_total++;
    if (s !== 0) $display("FAIL t6_hit_after_spurious stalls=%0d want 0", s);
    else n_pass++;
    for (int k = 0; k < 60; k++) begin
      a = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, s, r);
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL t6_queue left=%0d want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alloc_first();
    test_read_hit();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid();
    test_req_drop();
    test_spurious_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
